// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states, transaction
// owner, and the latency bounds of the attached single-port memory.
package mem_arb_pkg;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;
    localparam int CNT_W       = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_e;

    // Countdown preload for a read; an out-of-range latency is clamped so the
    // 2-bit counter can never wrap.
    function automatic logic [CNT_W-1:0] lat_preload(input int lat);
        int clamped;
        clamped = lat;
        if (clamped < MEM_LAT_MIN) clamped = MEM_LAT_MIN;
        if (clamped > MEM_LAT_MAX) clamped = MEM_LAT_MAX;
        return CNT_W'(clamped - 1);
    endfunction

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter that times the read latency of the memory port and
// flags when the countdown has reached zero.
module lat_counter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load has priority; decrementing saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetches and MEM-stage data accesses onto one
// fixed-latency single-port memory, data first, with per-requester stalls.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [63:0]       dm_wdata,
    output logic [63:0]       dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_LOAD = lat_preload(MEM_LAT);

    arb_state_e        state_q,   state_d;
    owner_e            owner_q,   owner_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              we_q,      we_d;
    logic [63:0]       wdata_q,   wdata_d;
    logic              cancel_q,  cancel_d;
    logic [63:0]       capture_q, capture_d;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;

    lat_counter #(
        .WIDTH (CNT_W)
    ) u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (LAT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state, request latching and memory-port drive. The port is only
    // driven during ISSUE so it reads as all-zero whenever it is not in use.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        cancel_d  = cancel_q;
        capture_d = capture_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_valid  = 1'b0;
        dm_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                cancel_d = 1'b0;
                if (dm_req) begin
                    owner_d = DATA;
                    addr_d  = dm_addr;
                    we_d    = dm_we;
                    wdata_d = dm_wdata;
                    state_d = ISSUE;
                end else if (if_req && !if_flush) begin
                    owner_d = FETCH;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    cnt_load = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    capture_d = mem_rdata;
                    state_d   = RESP;
                end
            end
            RESP: begin
                // A flush landing in the response cycle itself also kills the fetch.
                if (owner_q == DATA) begin
                    dm_valid = 1'b1;
                end else begin
                    if_valid = ~cancel_q & ~if_flush;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q != IDLE) && (owner_q == FETCH) && if_flush) begin
            cancel_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= FETCH;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            cancel_q  <= 1'b0;
            capture_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            cancel_q  <= cancel_d;
            capture_q <= capture_d;
        end
    end

    // Fetches read one 32-bit half of the 64-bit memory word.
    assign if_rdata = addr_q[2] ? capture_q[63:32] : capture_q[31:0];
    assign dm_rdata = capture_q;

    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural fixed-latency memory
// (MEM_LAT=2) and hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int MEM_LAT = 2;
    localparam int ADDR_W  = 8;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [31:0]       if_rdata;
    logic              if_valid;
    logic              if_stall;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [63:0]       dm_wdata;
    logic [63:0]       dm_rdata;
    logic              dm_valid;
    logic              dm_stall;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [63:0] mem_model [0:31];
    logic [63:0] rd_pipe   [0:MEM_LAT-1];
    logic        vld_pipe  [0:MEM_LAT-1];

    mem_port_arbiter #(
        .MEM_LAT (MEM_LAT),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .dm_stall  (dm_stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: preloaded while reset is high, read data appears MEM_LAT
    // cycles after mem_en and is poisoned in every other cycle.
    always @(posedge clk) begin
        if (rst) begin
            mem_model[1] <= 64'hAAAA_BBBB_CCCC_DDDD;
            mem_model[2] <= 64'h0123_4567_89AB_CDEF;
        end else if (mem_en && mem_we) begin
            mem_model[mem_addr[7:3]] <= mem_wdata;
        end
        rd_pipe[0]  <= mem_model[mem_addr[7:3]];
        vld_pipe[0] <= mem_en & ~mem_we;
        for (int i = 1; i < MEM_LAT; i++) begin
            rd_pipe[i]  <= rd_pipe[i-1];
            vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign mem_rdata = vld_pipe[MEM_LAT-1] ? rd_pipe[MEM_LAT-1] : 64'hDEAD_BEEF_DEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        if_flush = 1'b0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;

        // Reset held for two cycles
        tick();
        tick();
        check_output("rst_mem_en",   64'(mem_en),   64'h0);
        check_output("rst_mem_we",   64'(mem_we),   64'h0);
        check_output("rst_mem_addr", 64'(mem_addr), 64'h0);
        check_output("rst_if_valid", 64'(if_valid), 64'h0);
        check_output("rst_dm_valid", 64'(dm_valid), 64'h0);
        check_output("rst_if_rdata", 64'(if_rdata), 64'h0);
        check_output("rst_dm_rdata", dm_rdata,      64'h0);
        check_output("rst_if_stall", 64'(if_stall), 64'h0);
        check_output("rst_dm_stall", 64'(dm_stall), 64'h0);
        rst = 1'b0;
        tick();
        check_output("idle_mem_en_0", 64'(mem_en), 64'h0);
        tick();
        check_output("idle_mem_en_1", 64'(mem_en), 64'h0);

        // Fetch of the upper half (0x0C)
        $display("[TB] fetch 0x0C");
        if_req  = 1'b1;
        if_addr = 8'h0C;
        #1;
        check_output("f0_stall_T", 64'(if_stall), 64'h1);
        tick();
        check_output("f0_mem_en_T1",   64'(mem_en),   64'h1);
        check_output("f0_mem_we_T1",   64'(mem_we),   64'h0);
        check_output("f0_mem_addr_T1", 64'(mem_addr), 64'h0C);
        tick();
        check_output("f0_mem_en_T2",   64'(mem_en),   64'h0);
        check_output("f0_valid_T2",    64'(if_valid), 64'h0);
        tick();
        check_output("f0_valid_T3",    64'(if_valid), 64'h0);
        tick();
        check_output("f0_valid_T4",    64'(if_valid), 64'h1);
        check_output("f0_rdata_T4",    64'(if_rdata), 64'hAAAA_BBBB);
        check_output("f0_stall_T4",    64'(if_stall), 64'h0);
        if_req = 1'b0;
        tick();
        check_output("f0_valid_T5",    64'(if_valid), 64'h0);
        check_output("f0_mem_en_T5",   64'(mem_en),   64'h0);

        // Fetch of the lower half (0x08)
        $display("[TB] fetch 0x08");
        if_req  = 1'b1;
        if_addr = 8'h08;
        tick();
        check_output("f1_mem_addr_T1", 64'(mem_addr), 64'h08);
        tick();
        tick();
        tick();
        check_output("f1_valid_T4",    64'(if_valid), 64'h1);
        check_output("f1_rdata_T4",    64'(if_rdata), 64'hCCCC_DDDD);
        if_req = 1'b0;
        tick();

        // Simultaneous data load and fetch: data wins
        $display("[TB] simultaneous dm load 0x10 and fetch 0x08");
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 8'h10;
        if_req  = 1'b1;
        if_addr = 8'h08;
        tick();
        check_output("sim_mem_en_T1",   64'(mem_en),   64'h1);
        check_output("sim_mem_addr_T1", 64'(mem_addr), 64'h10);
        check_output("sim_if_stall_T1", 64'(if_stall), 64'h1);
        check_output("sim_dm_stall_T1", 64'(dm_stall), 64'h1);
        tick();
        tick();
        check_output("sim_if_stall_T3", 64'(if_stall), 64'h1);
        tick();
        check_output("sim_dm_valid_T4", 64'(dm_valid), 64'h1);
        check_output("sim_dm_rdata_T4", dm_rdata,      64'h0123_4567_89AB_CDEF);
        check_output("sim_if_valid_T4", 64'(if_valid), 64'h0);
        check_output("sim_if_stall_T4", 64'(if_stall), 64'h1);
        check_output("sim_dm_stall_T4", 64'(dm_stall), 64'h0);
        dm_req = 1'b0;
        tick();
        check_output("sim_mem_en_T5",   64'(mem_en),   64'h0);
        check_output("sim_if_stall_T5", 64'(if_stall), 64'h1);
        tick();
        check_output("sim_mem_en_T6",   64'(mem_en),   64'h1);
        check_output("sim_mem_addr_T6", 64'(mem_addr), 64'h08);
        tick();
        tick();
        tick();
        check_output("sim_if_valid_T9", 64'(if_valid), 64'h1);
        check_output("sim_if_rdata_T9", 64'(if_rdata), 64'hCCCC_DDDD);
        if_req = 1'b0;
        tick();

        // Store then load at 0x20
        $display("[TB] store 0x1234 to 0x20, then load back");
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 8'h20;
        dm_wdata = 64'h1234;
        tick();
        check_output("st_mem_en_T1",    64'(mem_en),   64'h1);
        check_output("st_mem_we_T1",    64'(mem_we),   64'h1);
        check_output("st_mem_addr_T1",  64'(mem_addr), 64'h20);
        check_output("st_mem_wdata_T1", mem_wdata,     64'h1234);
        tick();
        check_output("st_dm_valid_T2",  64'(dm_valid), 64'h1);
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_wdata = '0;
        tick();
        check_output("st_dm_valid_T3",  64'(dm_valid), 64'h0);
        dm_req  = 1'b1;
        dm_addr = 8'h20;
        tick();
        check_output("ld_mem_we_T1",    64'(mem_we),   64'h0);
        tick();
        tick();
        check_output("ld_dm_valid_T3",  64'(dm_valid), 64'h0);
        tick();
        check_output("ld_dm_valid_T4",  64'(dm_valid), 64'h1);
        check_output("ld_dm_rdata_T4",  dm_rdata,      64'h1234);
        dm_req = 1'b0;
        tick();

        // Flush during WAIT of a fetch
        $display("[TB] flush during fetch WAIT");
        if_req  = 1'b1;
        if_addr = 8'h0C;
        tick();
        tick();
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        check_output("fl_if_valid_T3",  64'(if_valid), 64'h0);
        tick();
        check_output("fl_if_valid_T4",  64'(if_valid), 64'h0);
        check_output("fl_if_stall_T4",  64'(if_stall), 64'h1);
        tick();
        check_output("fl_mem_en_T5",    64'(mem_en),   64'h0);
        tick();
        check_output("fl_mem_en_T6",    64'(mem_en),   64'h1);
        check_output("fl_mem_addr_T6",  64'(mem_addr), 64'h0C);
        tick();
        tick();
        tick();
        check_output("fl_if_valid_T9",  64'(if_valid), 64'h1);
        check_output("fl_if_rdata_T9",  64'(if_rdata), 64'hAAAA_BBBB);
        if_req = 1'b0;
        tick();

        // Reset in the middle of a read
        $display("[TB] reset during load WAIT");
        dm_req  = 1'b1;
        dm_addr = 8'h08;
        tick();
        tick();
        rst    = 1'b1;
        dm_req = 1'b0;
        tick();
        check_output("mr_mem_en",   64'(mem_en),   64'h0);
        check_output("mr_dm_valid", 64'(dm_valid), 64'h0);
        check_output("mr_if_valid", 64'(if_valid), 64'h0);
        check_output("mr_dm_rdata", dm_rdata,      64'h0);
        check_output("mr_if_rdata", 64'(if_rdata), 64'h0);
        check_output("mr_dm_stall", 64'(dm_stall), 64'h0);
        rst = 1'b0;
        tick();
        check_output("mr_dm_valid_after", 64'(dm_valid), 64'h0);
        check_output("mr_mem_en_after",   64'(mem_en),   64'h0);
        dm_req  = 1'b1;
        dm_addr = 8'h08;
        tick();
        check_output("mr_new_mem_en",   64'(mem_en),   64'h1);
        check_output("mr_new_mem_addr", 64'(mem_addr), 64'h08);
        tick();
        tick();
        tick();
        check_output("mr_new_dm_valid", 64'(dm_valid), 64'h1);
        check_output("mr_new_dm_rdata", dm_rdata,      64'hAAAA_BBBB_CCCC_DDDD);
        dm_req = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
